// File: rtl/ssd1306_byte_sequencer.sv
// ============================================================================
// Module   : ssd1306_byte_sequencer
// Purpose  : Byte source for the SSD1306 SPI shifter: panel reset, init list,
//            then an endless loop of address-window commands and pixel frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ssd1306_byte_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int FRAME_BYTES  = 1024
) (
  input  logic       clk_in,
  input  logic       reset,
  output logic       sr_start,
  output logic [7:0] sr_data,
  input  logic       sr_ready,
  input  logic       px_valid,
  input  logic [7:0] px_data,
  output logic       px_ready,
  output logic       oled_dc,
  output logic       oled_cs_n,
  output logic       oled_res_n,
  output logic       init_done,
  output logic       frame_done
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int BCW = $clog2(FRAME_BYTES + 1);

  localparam logic [RCW-1:0] c_RST_LAST  = RCW'(RESET_CYCLES - 1);
  localparam logic [BCW-1:0] c_BYTE_LAST = BCW'(FRAME_BYTES - 1);
  localparam logic [4:0]     c_INIT_LAST = 5'd24;
  localparam logic [4:0]     c_WIN_LAST  = 5'd5;

  localparam logic [2:0] c_ST_RST_LOW  = 3'd0;
  localparam logic [2:0] c_ST_RST_WAIT = 3'd1;
  localparam logic [2:0] c_ST_INIT     = 3'd2;
  localparam logic [2:0] c_ST_WINDOW   = 3'd3;
  localparam logic [2:0] c_ST_DATA     = 3'd4;

  logic [2:0]     r_state;
  logic [RCW-1:0] r_rst_cnt;
  logic [4:0]     r_idx;
  logic [BCW-1:0] r_byte_cnt;
  logic           r_dc;
  logic           r_cs_n;
  logic           r_res_n;
  logic           r_init_done;
  logic           r_frame_done;

  logic           w_start;
  logic [7:0]     w_byte;
  logic           w_px_ready;

  function automatic logic [7:0] f_init_rom(input logic [4:0] a);
    case (a)
      5'd0:    f_init_rom = 8'hAE;
      5'd1:    f_init_rom = 8'hD5;
      5'd2:    f_init_rom = 8'h80;
      5'd3:    f_init_rom = 8'hA8;
      5'd4:    f_init_rom = 8'h3F;
      5'd5:    f_init_rom = 8'hD3;
      5'd6:    f_init_rom = 8'h00;
      5'd7:    f_init_rom = 8'h40;
      5'd8:    f_init_rom = 8'h8D;
      5'd9:    f_init_rom = 8'h14;
      5'd10:   f_init_rom = 8'h20;
      5'd11:   f_init_rom = 8'h00;
      5'd12:   f_init_rom = 8'hA1;
      5'd13:   f_init_rom = 8'hC8;
      5'd14:   f_init_rom = 8'hDA;
      5'd15:   f_init_rom = 8'h12;
      5'd16:   f_init_rom = 8'h81;
      5'd17:   f_init_rom = 8'hCF;
      5'd18:   f_init_rom = 8'hD9;
      5'd19:   f_init_rom = 8'hF1;
      5'd20:   f_init_rom = 8'hDB;
      5'd21:   f_init_rom = 8'h40;
      5'd22:   f_init_rom = 8'hA4;
      5'd23:   f_init_rom = 8'hA6;
      5'd24:   f_init_rom = 8'hAF;
      default: f_init_rom = 8'h00;
    endcase
  endfunction

  // Full-panel column range 0..127, page range 0..7.
  function automatic logic [7:0] f_window(input logic [4:0] a);
    case (a)
      5'd0:    f_window = 8'h21;
      5'd1:    f_window = 8'h00;
      5'd2:    f_window = 8'h7F;
      5'd3:    f_window = 8'h22;
      5'd4:    f_window = 8'h00;
      5'd5:    f_window = 8'h07;
      default: f_window = 8'h00;
    endcase
  endfunction

  always_comb begin
    w_start    = 1'b0;
    w_byte     = 8'h00;
    w_px_ready = 1'b0;
    case (r_state)
      c_ST_INIT: begin
        w_start = sr_ready;
        w_byte  = f_init_rom(r_idx);
      end
      c_ST_WINDOW: begin
        w_start = sr_ready;
        w_byte  = f_window(r_idx);
      end
      c_ST_DATA: begin
        w_start    = sr_ready & px_valid;
        w_byte     = px_data;
        w_px_ready = sr_ready & px_valid;
      end
      default: ;
    endcase
  end

  assign sr_start   = w_start;
  assign sr_data    = w_start ? w_byte : 8'h00;
  assign px_ready   = w_px_ready;
  assign oled_dc    = r_dc;
  assign oled_cs_n  = r_cs_n;
  assign oled_res_n = r_res_n;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= c_ST_RST_LOW;
      r_rst_cnt    <= '0;
      r_idx        <= '0;
      r_byte_cnt   <= '0;
      r_dc         <= 1'b0;
      r_cs_n       <= 1'b1;
      r_res_n      <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        c_ST_RST_LOW: begin
          if (r_rst_cnt == c_RST_LAST) begin
            r_rst_cnt <= '0;
            r_res_n   <= 1'b1;
            r_state   <= c_ST_RST_WAIT;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        c_ST_RST_WAIT: begin
          if (r_rst_cnt == c_RST_LAST) begin
            r_cs_n  <= 1'b0;
            r_idx   <= '0;
            r_state <= c_ST_INIT;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        c_ST_INIT: begin
          if (w_start) begin
            r_dc <= 1'b0;
            if (r_idx == c_INIT_LAST) begin
              r_init_done <= 1'b1;
              r_idx       <= '0;
              r_state     <= c_ST_WINDOW;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        c_ST_WINDOW: begin
          // dc only flips to command on the first window load, after the
          // last pixel byte has finished shifting.
          if (w_start) begin
            r_dc <= 1'b0;
            if (r_idx == c_WIN_LAST) begin
              r_byte_cnt <= '0;
              r_state    <= c_ST_DATA;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        c_ST_DATA: begin
          if (w_start) begin
            r_dc <= 1'b1;
            if (r_byte_cnt == c_BYTE_LAST) begin
              r_frame_done <= 1'b1;
              r_idx        <= '0;
              r_state      <= c_ST_WINDOW;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        default: r_state <= c_ST_RST_LOW;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd1306_byte_sequencer.sv
// ============================================================================
// Module   : tb_ssd1306_byte_sequencer
// Purpose  : Randomized bench for ssd1306_byte_sequencer against a byte-stream
//            reference model, with a behavioural SPI shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ssd1306_byte_sequencer;

  localparam int RC = 4;
  localparam int FB = 4;
  localparam int W  = 6 + FB;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       sr_start;
  logic [7:0] sr_data;
  logic       sr_ready;
  logic       px_valid = 1'b0;
  logic [7:0] px_data;
  logic       px_ready;
  logic       oled_dc, oled_cs_n, oled_res_n, init_done, frame_done;

  ssd1306_byte_sequencer #(.RESET_CYCLES(RC), .FRAME_BYTES(FB)) dut (
    .clk_in(clk_in), .reset(reset),
    .sr_start(sr_start), .sr_data(sr_data), .sr_ready(sr_ready),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .oled_dc(oled_dc), .oled_cs_n(oled_cs_n), .oled_res_n(oled_res_n),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] rom_t [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                             8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                             8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                             8'hAF};
  logic [7:0] win_t [6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  logic [7:0] pix   [1024];

  // Shifter: busy for 9 cycles after each load; hold forces it not-ready.
  int busy = 0;
  bit hold = 1'b0;
  int src_cnt = 0;
  assign sr_ready = (busy == 0) && !hold;
  assign px_data  = px_valid ? pix[src_cnt % 1024] : 8'h5A;

  always @(posedge clk_in) begin
    if (sr_start) busy <= 9;
    else if (busy != 0) busy <= busy - 1;
    if (px_ready) src_cnt <= src_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: n = edges since reset release, p = bytes loaded since reset,
  // k = pixel bytes consumed overall.
  bit  armed = 1'b0;
  int  n = 0, p = 0, k = 0;
  bit  mdc = 1'b0, mfd = 1'b0;
  int  lc = 0;
  bit  pend = 1'b0;
  logic [7:0] log_data [64];
  logic       log_dc   [64];
  int  ld_n [64];
  int  rise_n = -1, fall_n = -1, id_n = -1, fd_n = -1, fd_count = 0;

  initial forever begin
    int  q;
    bit  is_d, e_start;
    logic [7:0] e_byte;
    @(negedge clk_in);
    q       = (p >= 25) ? (p - 25) % W : 0;
    is_d    = (p >= 25) && (q >= 6);
    e_start = (n >= 2 * RC) && sr_ready && (is_d ? px_valid : 1'b1);
    e_byte  = (p < 25) ? rom_t[p] : ((q < 6) ? win_t[q] : pix[k % 1024]);
    if (armed) begin
      chk("sr_start", sr_start, e_start);
      chk("sr_data", sr_data, e_start ? e_byte : 8'h00);
      chk("px_ready", px_ready, e_start && is_d);
      chk("oled_res_n", oled_res_n, n >= RC);
      chk("oled_cs_n", oled_cs_n, n < 2 * RC);
      chk("oled_dc", oled_dc, mdc);
      chk("init_done", init_done, p >= 25);
      chk("frame_done", frame_done, mfd);
      if (pend && lc < 64) begin
        log_dc[lc] = oled_dc;
        lc++;
      end
      pend = 1'b0;
      if (sr_start === 1'b1 && lc < 64) begin
        log_data[lc] = sr_data;
        ld_n[lc]     = n;
        pend         = 1'b1;
      end
      if (oled_res_n === 1'b1 && rise_n < 0) rise_n = n;
      if (oled_cs_n === 1'b0 && fall_n < 0) fall_n = n;
      if (init_done === 1'b1 && id_n < 0) id_n = n;
      if (frame_done === 1'b1) begin
        if (fd_n < 0) fd_n = n;
        fd_count++;
      end
    end
    if (e_start && is_d) k++;
    if (reset) begin
      armed = 1'b1;
      n = 0; p = 0; mdc = 1'b0; mfd = 1'b0;
      lc = 0; pend = 1'b0;
      rise_n = -1; fall_n = -1; id_n = -1; fd_n = -1; fd_count = 0;
    end else begin
      if (n < 100000) n++;
      mfd = 1'b0;
      if (e_start) begin
        mdc = is_d;
        if (is_d && q == W - 1) mfd = 1'b1;
        p++;
      end
    end
  end

  task automatic wait_p(input int target, input bit rnd, input int budget);
    int c = 0;
    while (p < target && c < budget) begin
      @(posedge clk_in); #1;
      if (rnd) px_valid = 1'($urandom_range(0, 1));
      c++;
    end
    if (p < target) chk("timeout_wait_p", p, target);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) pix[i] = 8'($urandom);
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    px_valid = 1'b1;

    // Init, first window and first frame with a steady pixel source.
    wait_p(36, 1'b0, 3000);
    @(posedge clk_in); #1;
    chk("res_n_rise_cycle", rise_n, RC);
    chk("cs_n_fall_cycle", fall_n, 2 * RC);
    chk("rom_first", log_data[0], 8'hAE);
    chk("rom_last", log_data[24], 8'hAF);
    chk("rom_last_dc", log_dc[24], 1'b0);
    chk("init_done_edge", id_n, ld_n[24] + 1);
    for (int i = 0; i < 6; i++) chk("window_byte", log_data[25 + i], win_t[i]);
    chk("px0", log_data[31], 8'h11);
    chk("px1", log_data[32], 8'h22);
    chk("px2", log_data[33], 8'h33);
    chk("px3", log_data[34], 8'h44);
    chk("px0_dc", log_dc[31], 1'b1);
    chk("px3_dc", log_dc[34], 1'b1);
    chk("frame_done_edge", fd_n, ld_n[34] + 1);
    chk("frame_done_count", fd_count, 1);
    chk("next_window", log_data[35], 8'h21);
    chk("next_window_dc", log_dc[35], 1'b0);

    // Random px_valid gaps over several frames.
    wait_p(36 + 4 * W, 1'b1, 20000);

    // Reset in the middle of a frame while the shifter is busy.
    begin
      int c = 0;
      px_valid = 1'b1;
      while (!(p >= 25 && (p - 25) % W == 8 && busy > 0) && c < 3000) begin
        @(posedge clk_in); #1;
        c++;
      end
      chk("mid_data_reached", c < 3000, 1'b1);
    end
    reset = 1'b1;
    @(posedge clk_in); #1;
    chk("rst_res_n", oled_res_n, 1'b0);
    chk("rst_cs_n", oled_cs_n, 1'b1);
    chk("rst_dc", oled_dc, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_sr_start", sr_start, 1'b0);
    reset = 1'b0;

    // Stall the shifter mid-init, then release it.
    wait_p(10, 1'b0, 3000);
    hold = 1'b1;
    repeat (40) @(posedge clk_in);
    #1 hold = 1'b0;
    wait_p(40, 1'b1, 5000);
    @(posedge clk_in); #1;
    chk("restart_res_n_rise", rise_n, RC);
    chk("restart_rom10", log_data[10], 8'h20);
    chk("restart_rom24", log_data[24], 8'hAF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire

// File: doc/ssd1306_byte_sequencer.md
Name: ssd1306_byte_sequencer

Overview:
Upstream byte source for the 8-bit SPI shift register that drives an SSD1306 128x64 OLED. It runs the panel hardware-reset pulse, sends a fixed init command list, then loops forever. Each loop iteration sends an address-window command list, then streams one frame of pixel bytes from a valid/ready source. It also drives oled_dc (command/data), oled_cs_n and oled_res_n. The shift register produces sclk and mosi.

Parameters:
RESET_CYCLES, 16, clk_in cycles for each reset phase (res_n low, then post-reset wait); must be >=1
FRAME_BYTES, 1024, data bytes per frame (128x64/8); must be >=1

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high reset
sr_start  output  1  byte-load strobe to shift register
sr_data  output  8  byte to shift register; valid only with sr_start, 0 otherwise
sr_ready  input  1  shift register idle/accepting (combinational, from shifter)
px_valid  input  1  pixel byte available
px_data  input  8  pixel byte (page-major, column order)
px_ready  output  1  pixel byte consumed this cycle
oled_dc  output  1  0=command, 1=data; registered
oled_cs_n  output  1  panel chip select, active low; registered
oled_res_n  output  1  panel reset, active low; registered
init_done  output  1  high once the init list is fully issued; sticky until reset
frame_done  output  1  one-cycle pulse when the last data byte of a frame is accepted

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk_in.
- Reset values: oled_res_n=0, oled_cs_n=1, oled_dc=0, init_done=0, frame_done=0. Combinational sr_start=0, sr_data=0 and px_ready=0 follow from state RST_LOW. Reset mid-operation aborts immediately, with no flush of an in-flight byte.
- FSM states:
  - RST_LOW: oled_res_n=0 for RESET_CYCLES cycles, then RST_WAIT.
  - RST_WAIT: oled_res_n=1, cs_n=1 for RESET_CYCLES cycles. Then go to INIT, setting oled_cs_n=0 and idx=0.
  - INIT: send ROM bytes 0..24 with dc=0. After byte 24 is accepted, set init_done=1, idx=0, go to WINDOW.
  - WINDOW: send 0x21,0x00,0x7F,0x22,0x00,0x07 with dc=0. After the 6th byte, go to DATA with byte_cnt=0.
  - DATA: send FRAME_BYTES bytes from px_data with dc=1. The acceptance of byte FRAME_BYTES-1 pulses frame_done and goes to WINDOW with idx=0.
- Init ROM (index 0..24): AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- Handshake, combinational, no register stage:
  - INIT/WINDOW: sr_start = sr_ready. In DATA: sr_start = sr_ready & px_valid; px_ready = that same term.
  - sr_data = ROM/window byte or px_data while sr_start=1, else 0.
- Advance: idx and byte_cnt increment only on cycles where sr_start=1. The state transition occurs on the same edge as the last byte's acceptance.
- oled_dc is registered. It is updated on the sr_start edge to the class of the byte being loaded, so it is stable for the whole 8-bit shift. It does not change while sr_ready=0.
- oled_cs_n stays low from INIT entry until reset. It is never toggled between bytes.
- Back-to-back: the shifter drops sr_ready the cycle after a load, so at most one sr_start per shift. The sequencer never holds sr_start high across consecutive cycles.
- px_valid may drop at any time in DATA. With px_valid=0: no start, no count, dc held. px_valid in any other state is ignored (px_ready=0).
- The last DATA byte is still shifting when WINDOW begins. The first window command waits for sr_ready, and dc goes 0 only on that load.
- Counters: idx 5 bits (max 24); byte_cnt width $clog2(FRAME_BYTES+1). The reset-phase counter is wide enough for RESET_CYCLES. No wrap beyond the terminal values.

Test Plan:
- Reset then release, RESET_CYCLES=4:
  - oled_res_n=0 for exactly 4 cycles, then 1.
  - cs_n=1 for 4 further cycles, then 0.
  - No sr_start before cs_n falls.
- Init, with a behavioural shifter model (ready low 9 cycles after load):
  - Exactly 25 loads carrying the ROM bytes in order, each with oled_dc=0.
  - init_done rises on the edge after the AF load.
- Window + frame, FRAME_BYTES=4, px_valid=1 with data 11,22,33,44:
  - Loads 21 00 7F 22 00 07 (dc=0), then 11 22 33 44 (dc=1).
  - frame_done pulses once, coincident with the 44 acceptance edge.
  - Next load is 21 with dc=0.
- px_valid gaps, FRAME_BYTES=4, px_valid toggled 1,0,0,1 around ready windows:
  - No sr_start or px_ready while px_valid=0.
  - byte_cnt and dc hold.
  - All 4 bytes are delivered unduplicated.
- Reset asserted mid-DATA (byte 2 of 4) while the shifter is busy:
  - Next edge gives res_n=0, cs_n=1, dc=0, init_done=0, sr_start=0.
  - Full reset/init sequence restarts.
- sr_ready held low indefinitely in INIT:
  - sr_start stays 0 and idx frozen.
  - Releasing sr_ready resumes at the same ROM index.
